// File: rtl/serial_parity_checker_if.sv
// Serial parity checker bus: serial bit input side plus decoded word output side.
// PARITY_ERR_COUNT_EN adds the saturating err_cnt output.
interface serial_parity_checker_if #(
  parameter int DATA_W = 8
);
  logic              bit_in;
  logic              bit_valid;
  logic              abort;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              busy;
`ifdef PARITY_ERR_COUNT_EN
  logic [7:0]        err_cnt;
`endif

  // Checker side
  modport slave (
    input  bit_in, bit_valid, abort,
`ifdef PARITY_ERR_COUNT_EN
    output err_cnt,
`endif
    output data_out, data_valid, parity_err, busy
  );

  // Line sampler / consumer side
  modport master (
    output bit_in, bit_valid, abort,
`ifdef PARITY_ERR_COUNT_EN
    input  err_cnt,
`endif
    input  data_out, data_valid, parity_err, busy
  );
endinterface

// File: rtl/serial_parity_checker.sv
// Serial parity checker: deserialises DATA_W data bits (LSB first) plus one
// parity bit, checks parity and presents the word with a one-cycle valid pulse.
// Optional macro PARITY_ERR_COUNT_EN adds an 8-bit saturating error counter.
module serial_parity_checker #(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_parity_checker_if.slave bus
);
  localparam int   CW  = $clog2(DATA_W + 1);
  localparam logic ODD = (ODD_PARITY != 0);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PAR = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              par_q, par_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              parity_err_q, parity_err_d;
`ifdef PARITY_ERR_COUNT_EN
  logic [7:0]        err_cnt_q, err_cnt_d;
`endif

  // Next-state, shift/parity accumulation and frame completion
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    par_d        = par_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    parity_err_d = parity_err_q;
`ifdef PARITY_ERR_COUNT_EN
    err_cnt_d    = err_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        // abort is meaningless here; a qualified bit always starts a frame
        if (bus.bit_valid) begin
          shift_d = {{(DATA_W-1){1'b0}}, bus.bit_in};
          par_d   = bus.bit_in;
          cnt_d   = CW'(1);
          state_d = DATA;
        end
      end
      DATA: begin
        if (bus.abort) begin
          cnt_d   = '0;
          par_d   = 1'b0;
          state_d = IDLE;
        end else if (bus.bit_valid) begin
          // Loop decode keeps the counter width independent of the index width
          for (int i = 0; i < DATA_W; i++)
            if (cnt_q == CW'(i)) shift_d[i] = bus.bit_in;
          par_d = par_q ^ bus.bit_in;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(DATA_W - 1)) state_d = PAR;
        end
      end
      PAR: begin
        if (bus.abort) begin
          cnt_d   = '0;
          par_d   = 1'b0;
          state_d = IDLE;
        end else if (bus.bit_valid) begin
          parity_err_d = par_q ^ bus.bit_in ^ ODD;
          data_out_d   = shift_q;
          data_valid_d = 1'b1;
          cnt_d        = '0;
          par_d        = 1'b0;
          state_d      = IDLE;
`ifdef PARITY_ERR_COUNT_EN
          if (parity_err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
`endif
        end
      end
      default: begin
        cnt_d   = '0;
        par_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      par_q        <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
`ifdef PARITY_ERR_COUNT_EN
      err_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      par_q        <= par_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
`ifdef PARITY_ERR_COUNT_EN
      err_cnt_q    <= err_cnt_d;
`endif
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.busy       = (state_q != IDLE);
`ifdef PARITY_ERR_COUNT_EN
  assign bus.err_cnt    = err_cnt_q;
`endif

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed bench: an even-parity and an odd-parity checker see the same
// serial stream, so each frame exercises both conventions.
module tb_serial_parity_checker;
  logic clk;
  logic rst;
  int   total;
  int   bad;
`ifdef PARITY_ERR_COUNT_EN
  int   exp_cnt;
`endif

  serial_parity_checker_if #(.DATA_W(8)) ife ();
  serial_parity_checker_if #(.DATA_W(8)) ifo ();

  assign ifo.bit_in    = ife.bit_in;
  assign ifo.bit_valid = ife.bit_valid;
  assign ifo.abort     = ife.abort;

  serial_parity_checker #(.DATA_W(8), .ODD_PARITY(0)) dut_even (.clk(clk), .rst(rst), .bus(ife));
  serial_parity_checker #(.DATA_W(8), .ODD_PARITY(1)) dut_odd  (.clk(clk), .rst(rst), .bus(ifo));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send_bit(input logic b);
    ife.bit_in    = b;
    ife.bit_valid = 1'b1;
    @(posedge clk); #1;
    ife.bit_valid = 1'b0;
    ife.bit_in    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Data bits only; gapped inserts i%4 idle cycles after each bit
  task automatic send_data(input logic [7:0] d, input bit gapped);
    for (int i = 0; i < 8; i++) begin
      send_bit(d[i]);
      if (gapped) idle(i % 4);
    end
  endtask

  task automatic test_reset;
    total++; if (ife.data_out !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", ife.data_out); end
    total++; if (ife.data_valid !== 1'b0) begin bad++; $display("FAIL reset_dv got=%b exp=0", ife.data_valid); end
    total++; if (ife.parity_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", ife.parity_err); end
    total++; if (ife.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", ife.busy); end
`ifdef PARITY_ERR_COUNT_EN
    total++; if (ife.err_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", ife.err_cnt); end
`endif
  endtask

  task automatic test_even_good;
    send_data(8'h0D, 1'b0);
    total++; if (ife.busy !== 1'b1) begin bad++; $display("FAIL good_busy_par got=%b exp=1", ife.busy); end
    send_bit(1'b1);
    total++; if (ife.data_valid !== 1'b1) begin bad++; $display("FAIL good_dv got=%b exp=1", ife.data_valid); end
    total++; if (ife.data_out !== 8'h0D) begin bad++; $display("FAIL good_dout got=%h exp=0d", ife.data_out); end
    total++; if (ife.parity_err !== 1'b0) begin bad++; $display("FAIL good_err got=%b exp=0", ife.parity_err); end
    total++; if (ife.busy !== 1'b0) begin bad++; $display("FAIL good_busy got=%b exp=0", ife.busy); end
    idle(1);
    total++; if (ife.data_valid !== 1'b0) begin bad++; $display("FAIL good_dv_pulse got=%b exp=0", ife.data_valid); end
  endtask

  task automatic test_even_bad;
    send_data(8'h0D, 1'b0);
    send_bit(1'b0);
    total++; if (ife.data_valid !== 1'b1) begin bad++; $display("FAIL bad_dv got=%b exp=1", ife.data_valid); end
    total++; if (ife.data_out !== 8'h0D) begin bad++; $display("FAIL bad_dout got=%h exp=0d", ife.data_out); end
    total++; if (ife.parity_err !== 1'b1) begin bad++; $display("FAIL bad_err got=%b exp=1", ife.parity_err); end
`ifdef PARITY_ERR_COUNT_EN
    exp_cnt = 1;
    total++; if (ife.err_cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL bad_cnt got=%0d exp=%0d", ife.err_cnt, exp_cnt); end
`endif
    idle(3);
    total++; if (ife.data_out !== 8'h0D || ife.parity_err !== 1'b1) begin
      bad++; $display("FAIL hold got=%h/%b exp=0d/1", ife.data_out, ife.parity_err); end
    total++; if (ife.data_valid !== 1'b0) begin bad++; $display("FAIL hold_dv got=%b exp=0", ife.data_valid); end
  endtask

  task automatic test_odd;
    send_data(8'hFF, 1'b0);
    send_bit(1'b1);
    total++; if (ifo.data_valid !== 1'b1 || ifo.data_out !== 8'hFF) begin
      bad++; $display("FAIL odd1_dout got=%b/%h exp=1/ff", ifo.data_valid, ifo.data_out); end
    total++; if (ifo.parity_err !== 1'b0) begin bad++; $display("FAIL odd1_err got=%b exp=0", ifo.parity_err); end
    total++; if (ife.parity_err !== 1'b1) begin bad++; $display("FAIL odd1_even_err got=%b exp=1", ife.parity_err); end
`ifdef PARITY_ERR_COUNT_EN
    exp_cnt = 2;
    total++; if (ife.err_cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL odd1_cnt got=%0d exp=%0d", ife.err_cnt, exp_cnt); end
`endif
    idle(1);
    send_data(8'hFF, 1'b0);
    send_bit(1'b0);
    total++; if (ifo.parity_err !== 1'b1) begin bad++; $display("FAIL odd0_err got=%b exp=1", ifo.parity_err); end
    total++; if (ife.parity_err !== 1'b0) begin bad++; $display("FAIL odd0_even_err got=%b exp=0", ife.parity_err); end
    idle(1);
  endtask

  task automatic test_gapped;
    send_bit(1'b1);
    idle(2);
    total++; if (ife.busy !== 1'b1) begin bad++; $display("FAIL gap_busy got=%b exp=1", ife.busy); end
    for (int i = 1; i < 8; i++) begin
      send_bit(1'((8'hA5 >> i) & 8'h01));
      idle(i % 4);
    end
    send_bit(1'b0);
    total++; if (ife.data_valid !== 1'b1 || ife.data_out !== 8'hA5) begin
      bad++; $display("FAIL gap_dout got=%b/%h exp=1/a5", ife.data_valid, ife.data_out); end
    total++; if (ife.parity_err !== 1'b0) begin bad++; $display("FAIL gap_err got=%b exp=0", ife.parity_err); end
  endtask

  task automatic test_back_to_back;
    send_data(8'h0D, 1'b0);
    send_bit(1'b1);
    total++; if (ife.data_valid !== 1'b1 || ife.data_out !== 8'h0D) begin
      bad++; $display("FAIL b2b_first got=%b/%h exp=1/0d", ife.data_valid, ife.data_out); end
    // bit 0 of the next frame goes in during the pulse cycle
    send_bit(1'b0);
    total++; if (ife.data_valid !== 1'b0 || ife.busy !== 1'b1) begin
      bad++; $display("FAIL b2b_start got=dv%b/busy%b exp=0/1", ife.data_valid, ife.busy); end
    for (int i = 1; i < 8; i++) send_bit(1'((8'h3C >> i) & 8'h01));
    send_bit(1'b0);
    total++; if (ife.data_valid !== 1'b1 || ife.data_out !== 8'h3C) begin
      bad++; $display("FAIL b2b_second got=%b/%h exp=1/3c", ife.data_valid, ife.data_out); end
    total++; if (ife.parity_err !== 1'b0) begin bad++; $display("FAIL b2b_err got=%b exp=0", ife.parity_err); end
    idle(1);
  endtask

  task automatic test_abort;
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    ife.abort = 1'b1; ife.bit_valid = 1'b1; ife.bit_in = 1'b1;
    @(posedge clk); #1;
    ife.abort = 1'b0; ife.bit_valid = 1'b0; ife.bit_in = 1'b0;
    total++; if (ife.busy !== 1'b0 || ife.data_valid !== 1'b0) begin
      bad++; $display("FAIL abort_data got=busy%b/dv%b exp=0/0", ife.busy, ife.data_valid); end
    idle(1);
    total++; if (ife.data_valid !== 1'b0 || ife.data_out !== 8'h3C) begin
      bad++; $display("FAIL abort_hold got=%b/%h exp=0/3c", ife.data_valid, ife.data_out); end
    // abort while waiting for the parity bit
    send_data(8'h81, 1'b0);
    ife.abort = 1'b1; ife.bit_valid = 1'b1;
    @(posedge clk); #1;
    ife.abort = 1'b0; ife.bit_valid = 1'b0;
    total++; if (ife.busy !== 1'b0 || ife.data_valid !== 1'b0 || ife.data_out !== 8'h3C) begin
      bad++; $display("FAIL abort_par got=busy%b/dv%b/%h exp=0/0/3c", ife.busy, ife.data_valid, ife.data_out); end
    send_data(8'h81, 1'b0);
    send_bit(1'b0);
    total++; if (ife.data_valid !== 1'b1 || ife.data_out !== 8'h81 || ife.parity_err !== 1'b0) begin
      bad++; $display("FAIL abort_next got=%b/%h/%b exp=1/81/0", ife.data_valid, ife.data_out, ife.parity_err); end
    idle(1);
  endtask

  task automatic test_async_reset;
    send_data(8'hF0, 1'b0);
    total++; if (ife.busy !== 1'b1) begin bad++; $display("FAIL arst_pre_busy got=%b exp=1", ife.busy); end
    #2 rst = 1'b1;
    #1;
    total++; if (ife.busy !== 1'b0 || ife.data_out !== 8'h00 || ife.data_valid !== 1'b0 || ife.parity_err !== 1'b0) begin
      bad++; $display("FAIL arst_now got=busy%b/%h/dv%b/err%b exp=0/00/0/0", ife.busy, ife.data_out, ife.data_valid, ife.parity_err); end
`ifdef PARITY_ERR_COUNT_EN
    exp_cnt = 0;
    total++; if (ife.err_cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL arst_cnt got=%0d exp=0", ife.err_cnt); end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
    total++; if (ife.data_valid !== 1'b0 || ife.busy !== 1'b0) begin
      bad++; $display("FAIL arst_after got=dv%b/busy%b exp=0/0", ife.data_valid, ife.busy); end
  endtask

`ifdef PARITY_ERR_COUNT_EN
  task automatic test_err_sat;
    for (int f = 0; f < 260; f++) begin
      send_data(8'h00, 1'b0);
      send_bit(1'b1);
    end
    total++; if (ife.err_cnt !== 8'd255) begin bad++; $display("FAIL sat_cnt got=%0d exp=255", ife.err_cnt); end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    ife.bit_in = 1'b0; ife.bit_valid = 1'b0; ife.abort = 1'b0;
    idle(3);
    test_reset;
    rst = 1'b0;
    idle(1);
    test_even_good;
    test_even_bad;
    test_odd;
    test_gapped;
    test_back_to_back;
    test_abort;
    test_async_reset;
`ifdef PARITY_ERR_COUNT_EN
    test_err_sat;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
